// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Contents: default digit count, segment pattern constants (bit6=a .. bit0=g),
// decode result struct, scan FSM state type and the pattern decode function.
package seg_scan_pkg;

  localparam int unsigned DIGITS_DEF = 8;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_9_ALT = 7'b1110011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;

  // valid: table hit; blank: all segments dark; neither: unknown pattern
  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BADSEL,
    ST_SETTLING,
    ST_HELD
  } scan_state_t;

  // Pattern to hex value lookup
  function automatic seg_dec_t decode_seg7(input logic [6:0] seg);
    seg_dec_t d;
    d.valid  = 1'b1;
    d.blank  = 1'b0;
    d.nibble = 4'h0;
    case (seg)
      SEG_0:            d.nibble = 4'h0;
      SEG_1:            d.nibble = 4'h1;
      SEG_2:            d.nibble = 4'h2;
      SEG_3:            d.nibble = 4'h3;
      SEG_4:            d.nibble = 4'h4;
      SEG_5:            d.nibble = 4'h5;
      SEG_6:            d.nibble = 4'h6;
      SEG_7:            d.nibble = 4'h7;
      SEG_8:            d.nibble = 4'h8;
      SEG_9, SEG_9_ALT: d.nibble = 4'h9;
      SEG_A:            d.nibble = 4'hA;
      SEG_B:            d.nibble = 4'hB;
      SEG_C:            d.nibble = 4'hC;
      SEG_D:            d.nibble = 4'hD;
      SEG_E:            d.nibble = 4'hE;
      SEG_F:            d.nibble = 4'hF;
      SEG_BLANK: begin
        d.valid = 1'b0;
        d.blank = 1'b1;
      end
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational seven-segment pattern decoder.
// Ports: seg (pattern, bit6=a .. bit0=g) -> valid_c (table hit),
// blank_c (pattern all dark), nibble_c (decoded hex value, 0 when not valid_c).
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid_c,
  output logic       blank_c,
  output logic [3:0] nibble_c
);

  seg_dec_t dec;

  always_comb begin
    dec = decode_seg7(seg);
  end

  assign valid_c  = dec.valid;
  assign blank_c  = dec.blank;
  assign nibble_c = dec.nibble;

endmodule

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan bus decoder: rebuilds the displayed hex digits from the
// multiplexed (one-hot select, segment pattern) bus and publishes a snapshot
// once every digit position has been captured.
// Ports: clk, rst2 (sync active-high reset), led_data (pattern a..g),
// led_choose (one-hot digit select), digits_out / blank_mask (committed
// snapshot), frame_valid (commit pulse), err_seg (unknown pattern captured),
// err_sel (non-one-hot select seen).
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst2,
  input  logic [6:0]          led_data,
  input  logic [DIGITS-1:0]   led_choose,
  output logic [4*DIGITS-1:0] digits_out,
  output logic [DIGITS-1:0]   blank_mask,
  output logic                frame_valid,
  output logic                err_seg,
  output logic                err_sel
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  logic [DIGITS-1:0]   sel_q, sel_p;
  logic [6:0]          seg_q, seg_p;
  logic [CNT_W-1:0]    cnt_q, cnt_c;
  scan_state_t         state_q, state_c;
  logic [4*DIGITS-1:0] shadow_q, shadow_c;
  logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_c;
  logic [DIGITS-1:0]   seen_q, seen_c;
  logic                pair_changed_c, sel_onehot_c;
  logic                capture_c, bad_entry_c, seg_miss_c, commit_c;
  logic [IDX_W-1:0]    idx_c;
  logic                dec_valid_c, dec_blank_c;
  logic [3:0]          dec_nibble_c;

  seg7_decode u_dec (
    .seg      (seg_q),
    .valid_c  (dec_valid_c),
    .blank_c  (dec_blank_c),
    .nibble_c (dec_nibble_c)
  );

  // Input register plus one-cycle history for change detection
  always_ff @(posedge clk) begin
    if (rst2) begin
      sel_q <= '0;
      seg_q <= '0;
      sel_p <= '0;
      seg_p <= '0;
    end else begin
      sel_q <= led_choose;
      seg_q <= led_data;
      sel_p <= sel_q;
      seg_p <= seg_q;
    end
  end

  // Dwell counter: reload on any pair change, otherwise count up to SETTLE
  always_comb begin
    pair_changed_c = (sel_q != sel_p) || (seg_q != seg_p);
    sel_onehot_c   = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
    cnt_c          = cnt_q;
    if (pair_changed_c) begin
      cnt_c = CNT_W'(1);
    end else if (cnt_q >= SETTLE_C) begin
      cnt_c = SETTLE_C;
    end else begin
      cnt_c = cnt_q + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst2) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_c;
      cnt_q   <= cnt_c;
    end
  end

  // FSM next state; HELD only persists while the captured pair is unchanged
  always_comb begin
    state_c     = state_q;
    capture_c   = 1'b0;
    bad_entry_c = 1'b0;
    if (sel_q == '0) begin
      state_c = ST_IDLE;
    end else if (!sel_onehot_c) begin
      state_c     = ST_BADSEL;
      bad_entry_c = (state_q != ST_BADSEL) || (sel_q != sel_p);
    end else if ((state_q == ST_HELD) && !pair_changed_c) begin
      state_c = ST_HELD;
    end else if (cnt_c == SETTLE_C) begin
      state_c   = ST_HELD;
      capture_c = 1'b1;
    end else begin
      state_c = ST_SETTLING;
    end
  end

  // Position of the single set select bit
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) idx_c = IDX_W'(i);
    end
  end

  // Shadow update; a commit clears seen before this cycle's capture lands
  always_comb begin
    commit_c       = &seen_q;
    shadow_c       = shadow_q;
    shadow_blank_c = shadow_blank_q;
    seen_c         = commit_c ? '0 : seen_q;
    seg_miss_c     = 1'b0;
    if (capture_c) begin
      if (dec_valid_c) begin
        shadow_c[{idx_c, 2'b00} +: 4] = dec_nibble_c;
        shadow_blank_c[idx_c]         = 1'b0;
        seen_c[idx_c]                 = 1'b1;
      end else if (dec_blank_c) begin
        shadow_blank_c[idx_c] = 1'b1;
        seen_c[idx_c]         = 1'b1;
      end else begin
        seg_miss_c = 1'b1;
      end
    end
  end

  // Shadow, seen and registered outputs
  always_ff @(posedge clk) begin
    if (rst2) begin
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      seen_q         <= '0;
      digits_out     <= '0;
      blank_mask     <= '0;
      frame_valid    <= 1'b0;
      err_seg        <= 1'b0;
      err_sel        <= 1'b0;
    end else begin
      shadow_q       <= shadow_c;
      shadow_blank_q <= shadow_blank_c;
      seen_q         <= seen_c;
      frame_valid    <= commit_c;
      err_seg        <= seg_miss_c;
      err_sel        <= bad_entry_c;
      if (commit_c) begin
        digits_out <= shadow_q;
        blank_mask <= shadow_blank_q;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: two instances (SETTLE=2 and SETTLE=1) share the
// same scan bus. A dwell-level reference model predicts every frame_valid,
// err_seg and err_sel pulse with its edge number; a monitor matches pulses.
module tb_seg_scan_decoder;

  localparam int K_FRAME = 0;
  localparam int K_SEG   = 1;
  localparam int K_SEL   = 2;

  logic        clk = 1'b0;
  logic        rst2;
  logic [6:0]  led_data;
  logic [7:0]  led_choose;
  logic [31:0] dig2, dig1;
  logic [7:0]  blk2, blk1;
  logic        fv2, fv1, es2, es1, esl2, esl1;

  always #5 clk = ~clk;

  seg_scan_decoder #(.DIGITS(8), .SETTLE(2)) u_dut_s2 (
    .clk(clk), .rst2(rst2), .led_data(led_data), .led_choose(led_choose),
    .digits_out(dig2), .blank_mask(blk2), .frame_valid(fv2),
    .err_seg(es2), .err_sel(esl2)
  );

  seg_scan_decoder #(.DIGITS(8), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst2(rst2), .led_data(led_data), .led_choose(led_choose),
    .digits_out(dig1), .blank_mask(blk1), .frame_valid(fv1),
    .err_seg(es1), .err_sel(esl1)
  );

  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [6:0] pat_9_alt = 7'b1110011;

  typedef struct {
    int          cyc;
    int          inst;
    int          kind;
    logic [31:0] dig;
    logic [7:0]  blk;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] m_shadow [2][8];
  logic [7:0] m_blank [2];
  logic [7:0] m_seen [2];
  logic [7:0] prev_sel;
  logic [6:0] prev_seg;
  int         run;
  int         edge_cnt = 0;
  logic       rst_s = 1'b1;
  bit         fin = 1'b0;
  bit         drained = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_s    <= rst2;
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic void push_ev(input int cyc, input int inst, input int kind,
                                  input logic [31:0] dig, input logic [7:0] blk);
    ev_t ev;
    ev.cyc = cyc; ev.inst = inst; ev.kind = kind; ev.dig = dig; ev.blk = blk;
    exp_q.push_back(ev);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_seen[k]  = '0;
      m_blank[k] = '0;
      for (int i = 0; i < 8; i++) m_shadow[k][i] = 4'h0;
    end
    prev_sel = '0;
    prev_seg = '0;
    run      = 0;
  endfunction

  // Capture of a settled digit by instance k, taking effect at edge cyc
  function automatic void model_capture(input int k, input logic [7:0] sel,
                                        input logic [6:0] seg, input int cyc);
    int          idx;
    int          val;
    logic [31:0] dig;
    idx = 0;
    val = -1;
    for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
    for (int v = 0; v < 16; v++) if (pat[v] == seg) val = v;
    if (seg == pat_9_alt) val = 9;
    if (seg == 7'b0) begin
      m_blank[k][idx] = 1'b1;
      m_seen[k][idx]  = 1'b1;
    end else if (val >= 0) begin
      m_shadow[k][idx] = 4'(val);
      m_blank[k][idx]  = 1'b0;
      m_seen[k][idx]   = 1'b1;
    end else begin
      push_ev(cyc, k, K_SEG, '0, '0);
    end
    if (m_seen[k] == 8'hFF) begin
      dig = '0;
      for (int i = 0; i < 8; i++) dig[4*i +: 4] = m_shadow[k][i];
      push_ev(cyc + 1, k, K_FRAME, dig, m_blank[k]);
      m_seen[k] = '0;
    end
  endfunction

  // One pin cycle seen by edge e: track how long the pair has been held
  function automatic void model_step(input logic [7:0] sel, input logic [6:0] seg, input int e);
    if (sel == prev_sel && seg == prev_seg) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
      if ($countones(sel) > 1 && sel != prev_sel)
        for (int k = 0; k < 2; k++) push_ev(e + 1, k, K_SEL, '0, '0);
    end
    prev_sel = sel;
    prev_seg = seg;
    if ($countones(sel) == 1)
      for (int k = 0; k < 2; k++)
        if (run == settle_of(k)) model_capture(k, sel, seg, e + 1);
  endfunction

  task automatic dwell(input logic [7:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      led_choose = sel;
      led_data   = seg;
      model_step(sel, seg, edge_cnt + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst2 = 1'b1; led_choose = '0; led_data = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    model_reset();
    model_step('0, '0, edge_cnt + 1);
  endtask

  function automatic string kind_name(input int kind);
    return (kind == K_FRAME) ? "frame_valid" : (kind == K_SEG) ? "err_seg" : "err_sel";
  endfunction

  function automatic void chk_reset(input int k, input logic fv, input logic es, input logic esl,
                                    input logic [31:0] dig, input logic [7:0] blk);
    n_checks++;
    if (!fv && !es && !esl && dig == '0 && blk == '0) n_pass++;
    else $display("FAIL reset_state inst%0d cycle %0d: got fv=%0b es=%0b esl=%0b digits=%h blank=%h, expected all 0",
                  k, edge_cnt, fv, es, esl, dig, blk);
  endfunction

  function automatic void chk_out(input int k, input logic fv, input logic es, input logic esl,
                                  input logic [31:0] dig, input logic [7:0] blk);
    for (int kind = 0; kind < 3; kind++) begin
      logic obs;
      int   idx;
      bit   ok;
      obs = (kind == K_FRAME) ? fv : (kind == K_SEG) ? es : esl;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].inst == k && exp_q[i].kind == kind && exp_q[i].cyc == edge_cnt) begin
          idx = i;
          break;
        end
      end
      if (obs || idx >= 0) begin
        n_checks++;
        ok = obs && (idx >= 0);
        if (ok && kind == K_FRAME) ok = (exp_q[idx].dig == dig) && (exp_q[idx].blk == blk);
        if (ok) n_pass++;
        else $display("FAIL %s inst%0d cycle %0d: got pulse=%0b digits=%h blank=%h, expected pulse=%0b digits=%h blank=%h",
                      kind_name(kind), k, edge_cnt, obs, dig, blk, idx >= 0,
                      (idx >= 0) ? exp_q[idx].dig : 32'h0, (idx >= 0) ? exp_q[idx].blk : 8'h0);
        if (idx >= 0) exp_q.delete(idx);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_s) begin
      chk_reset(0, fv2, es2, esl2, dig2, blk2);
      chk_reset(1, fv1, es1, esl1, dig1, blk1);
    end else begin
      chk_out(0, fv2, es2, esl2, dig2, blk2);
      chk_out(1, fv1, es1, esl1, dig1, blk1);
    end
    if (fin && !drained) begin
      drained = 1'b1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d expected events never seen, expected 0 (first inst%0d %s cycle %0d)",
                    exp_q.size(), exp_q[0].inst, kind_name(exp_q[0].kind), exp_q[0].cyc);
    end
  end

  initial begin
    rst2 = 1'b1; led_choose = '0; led_data = '0;
    model_reset();
    do_reset();
    dwell('0, '0, 3);
    // Values 1..8 on digits 0..7
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), pat[i + 1], 4);
    dwell('0, '0, 3);
    // Digit 3 dark
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), (i == 3) ? 7'b0 : pat[i + 1], 4);
    dwell('0, '0, 3);
    // Digit 5 unknown pattern, then rescanned with a legal one
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), (i == 5) ? 7'b1010101 : pat[i + 1], 4);
    dwell('0, '0, 3);
    dwell(8'h20, pat[6], 4);
    dwell('0, '0, 2);
    // Non-one-hot select held for 5 cycles
    dwell(8'b0000_0110, pat[2], 5);
    dwell('0, '0, 2);
    // Single-cycle dwells, two back-to-back passes
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) dwell(8'(1 << i), pat[(8 * p + i + 3) % 16], 1);
    dwell('0, '0, 4);
    // Partial frame interrupted by reset, then a full scan
    for (int i = 0; i < 5; i++) dwell(8'(1 << i), pat[(i + 10) % 16], 4);
    dwell('0, '0, 3);
    do_reset();
    dwell('0, '0, 2);
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), (i == 6) ? pat_9_alt : pat[i], 4);
    dwell('0, '0, 3);
    // Back-to-back frames with 2-cycle dwells, second all F
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), pat[7 - i], 2);
    for (int i = 0; i < 8; i++) dwell(8'(1 << i), pat[15], 2);
    dwell('0, '0, 4);
    // Random traffic
    for (int n = 0; n < 250; n++) begin
      logic [7:0] s;
      logic [6:0] p;
      int         r;
      r = int'($urandom_range(0, 9));
      if (r == 0) s = '0;
      else if (r == 1) begin
        s = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
        if ($countones(s) < 2 || s == prev_sel) s = '0;
      end else s = 8'(1 << $urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      if (r == 0) p = '0;
      else if (r == 1) p = 7'($urandom);
      else if (r == 2) p = pat_9_alt;
      else p = pat[$urandom_range(0, 15)];
      dwell(s, p, int'($urandom_range(1, 4)));
    end
    dwell('0, '0, 6);
    @(posedge clk);
    fin = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
